// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port, with a watchdog that halts on a hung bus.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        z,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        sel_addr,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        sel_pc_src,
  output logic        RF_WEN,
  output logic [1:0]  sel_ld,
  output logic [1:0]  sel_srcA,
  output logic [1:0]  sel_srcB,
  output logic [1:0]  sel_imm,
  output logic        sel_a,
  output logic        sel_comp,
  output logic [1:0]  sel_s,
  output logic [1:0]  sel_l,
  output logic [1:0]  sel_exec_out,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JAL    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          is_r;
  logic          wait_hit;
  logic          unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign is_r         = (opcode == OP_R);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // The cycle that would be wait number TIMEOUT_CYCLES diverts to HALT unless ready arrives.
  assign wait_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || (mem_req && mem_ready))
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    sel_addr     = 1'b0;
    ir_wen       = 1'b0;
    pc_wen       = 1'b0;
    sel_pc_src   = 1'b0;
    RF_WEN       = 1'b0;
    sel_ld       = 2'b00;
    sel_srcA     = 2'b00;
    sel_srcB     = 2'b00;
    sel_imm      = 2'b00;
    sel_a        = 1'b0;
    sel_comp     = 1'b0;
    sel_s        = 2'b00;
    sel_l        = 2'b00;
    sel_exec_out = 2'b00;
    retire       = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    state        = 3'd0;

    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          sel_srcB = 2'b10;
          if (mem_ready) begin
            ir_wen  = 1'b1;
            pc_wen  = 1'b1;
            state_d = S_DECODE;
          end else if (wait_hit) begin
            state_d = S_HALT;
          end
        end
        S_DECODE: begin
          sel_srcA = 2'b01;
          sel_srcB = 2'b01;
          sel_imm  = (opcode == OP_BEQ) ? 2'b10 : 2'b11;
          case (opcode)
            OP_R, OP_I, OP_LW, OP_SW: state_d = S_EXEC;
            OP_BEQ:                   state_d = S_BRANCH;
            OP_JAL:                   state_d = S_JAL;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          sel_srcA = 2'b10;
          sel_srcB = is_r ? 2'b00 : 2'b01;
          sel_imm  = (opcode == OP_SW) ? 2'b01 : 2'b00;
          state_d  = (opcode == OP_LW || opcode == OP_SW) ? S_MEM : S_WB;
          if (is_r || opcode == OP_I) begin
            case (funct3)
              3'b000: sel_a = is_r & instr[30];
              3'b001: sel_exec_out = 2'b11;
              3'b010: begin
                sel_a        = 1'b1;
                sel_comp     = 1'b1;
                sel_exec_out = 2'b01;
              end
              3'b011: begin
                sel_a        = 1'b1;
                sel_exec_out = 2'b01;
              end
              3'b100: sel_exec_out = 2'b10;
              3'b101: begin
                sel_s        = instr[30] ? 2'b11 : 2'b10;
                sel_exec_out = 2'b11;
              end
              3'b110: begin
                sel_l        = 2'b01;
                sel_exec_out = 2'b10;
              end
              default: begin
                sel_l        = 2'b10;
                sel_exec_out = 2'b10;
              end
            endcase
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          sel_addr = 1'b1;
          mem_we   = (opcode == OP_SW);
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_hit) begin
            state_d = S_HALT;
          end
        end
        S_WB: begin
          RF_WEN  = 1'b1;
          sel_ld  = (opcode == OP_LW) ? 2'b10 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          sel_srcA   = 2'b10;
          sel_a      = 1'b1;
          sel_pc_src = 1'b1;
          pc_wen     = z;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_JAL: begin
          RF_WEN     = 1'b1;
          sel_ld     = 2'b01;
          pc_wen     = 1'b1;
          sel_pc_src = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        default: bus_err = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: per-cycle output comparison
// against an instruction-plan reference model, plus CPI, watchdog and reset scenarios.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        z;
  logic        mem_ready;
  logic        mem_req, mem_we, sel_addr, ir_wen, pc_wen, sel_pc_src, RF_WEN;
  logic [1:0]  sel_ld, sel_srcA, sel_srcB, sel_imm;
  logic        sel_a, sel_comp;
  logic [1:0]  sel_s, sel_l, sel_exec_out;
  logic        retire, illegal, bus_err;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .sel_addr(sel_addr), .ir_wen(ir_wen),
    .pc_wen(pc_wen), .sel_pc_src(sel_pc_src), .RF_WEN(RF_WEN), .sel_ld(sel_ld),
    .sel_srcA(sel_srcA), .sel_srcB(sel_srcB), .sel_imm(sel_imm), .sel_a(sel_a),
    .sel_comp(sel_comp), .sel_s(sel_s), .sel_l(sel_l), .sel_exec_out(sel_exec_out),
    .retire(retire), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  logic [31:0] act_vec;
  assign act_vec = {3'b000, mem_req, mem_we, sel_addr, ir_wen, pc_wen, sel_pc_src, RF_WEN,
                    sel_ld, sel_srcA, sel_srcB, sel_imm, sel_a, sel_comp, sel_s, sel_l,
                    sel_exec_out, retire, illegal, bus_err, state};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction table: class R/I/L/S/B/J/X, alu = {sel_a, sel_comp, sel_s, sel_l, sel_exec_out}
  localparam int NE = 24;
  string      e_name [NE];
  logic [6:0] e_op   [NE];
  logic [2:0] e_f3   [NE];
  int         e_b30  [NE];
  logic [7:0] e_alu  [NE];
  byte        e_cls  [NE];
  int         ne = 0;

  task automatic add_e(input string n, input byte c, input logic [6:0] op, input logic [2:0] f3,
                       input int b30, input logic [7:0] alu);
    e_name[ne] = n; e_cls[ne] = c; e_op[ne] = op; e_f3[ne] = f3; e_b30[ne] = b30; e_alu[ne] = alu;
    ne++;
  endtask

  function automatic int find(input string n);
    for (int i = 0; i < NE; i++) if (e_name[i] == n) return i;
    return 0;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
  endfunction

  // Reference model: each instruction is a plan of phase letters walked one per cycle,
  // F and M advancing only on mem_ready.
  string       plan = "F";
  int          idx = 0;
  int          waits = 0;
  int          cur = 0;
  logic [31:0] cur_instr = '0;
  int          force_idx = -1;
  int          rdy_pct = 100;
  int          mem_hold = 0;
  logic        drv_rst = 1'b1;
  logic        last_retire = 1'b0;
  int          cyc = 0;

  task automatic pick_instr();
    int k;
    logic [31:0] w;
    logic [6:0] op;
    k = (force_idx >= 0) ? force_idx : int'($urandom_range(NE - 1));
    force_idx = -1;
    cur = k;
    w = $urandom;
    if (e_cls[k] == "X") begin
      do op = 7'($urandom); while (is_legal(op));
      w[6:0] = op;
    end else begin
      w[6:0] = e_op[k];
    end
    if (e_cls[k] == "R" || e_cls[k] == "I") begin
      w[14:12] = e_f3[k];
      if (e_b30[k] != 2) w[30] = (e_b30[k] == 1);
      if (e_cls[k] == "R") begin
        w[31] = 1'b0;
        w[29:25] = 5'b0;
      end
    end
    cur_instr = w;
    case (e_cls[k])
      "R", "I": plan = "FDEW";
      "L":      plan = "FDEMW";
      "S":      plan = "FDEM";
      "B":      plan = "FDB";
      "J":      plan = "FDJ";
      default:  plan = "FD";
    endcase
  endtask

  task automatic advance(input logic rdy, input logic r);
    byte ph;
    bit  step;
    if (r) begin
      plan = "F"; idx = 0; waits = 0;
      return;
    end
    ph = plan[idx];
    step = 1'b0;
    if (ph == "H") begin
      step = 1'b0;
    end else if (ph == "F" || ph == "M") begin
      if (rdy) begin
        waits = 0;
        step = 1'b1;
      end else begin
        waits++;
        if (waits == 16) begin
          plan = "H"; idx = 0; waits = 0;
        end
      end
    end else begin
      step = 1'b1;
    end
    if (step) begin
      if (ph == "F") begin
        pick_instr();
        idx = 1;
      end else if (idx + 1 >= plan.len()) begin
        plan = "F"; idx = 0;
      end else begin
        idx++;
      end
    end
  endtask

  function automatic logic [31:0] expect_vec(input byte ph, input logic rdy, input logic zz,
                                             input logic r);
    logic mreq = 0, mwe = 0, addr = 0, irw = 0, pcw = 0, pcs = 0, rfw = 0;
    logic [1:0] ld = 0, sa = 0, sb = 0, im = 0;
    logic a = 0, comp = 0, ret = 0, ill = 0, berr = 0;
    logic [1:0] s = 0, l = 0, ex = 0;
    logic [2:0] st = 0;
    byte c;
    c = e_cls[cur];
    if (!r) begin
      case (ph)
        "F": begin
          st = 0; mreq = 1; sb = 2'b10;
          if (rdy) begin irw = 1; pcw = 1; end
        end
        "D": begin
          st = 1; sa = 2'b01; sb = 2'b01;
          im = (c == "B") ? 2'b10 : 2'b11;
          ill = (c == "X");
        end
        "E": begin
          st = 2; sa = 2'b10;
          sb = (c == "R") ? 2'b00 : 2'b01;
          im = (c == "S") ? 2'b01 : 2'b00;
          if (c == "R" || c == "I") {a, comp, s, l, ex} = e_alu[cur];
        end
        "M": begin
          st = 3; mreq = 1; addr = 1; mwe = (c == "S");
          ret = (c == "S") && rdy;
        end
        "W": begin
          st = 4; rfw = 1; ld = (c == "L") ? 2'b10 : 2'b00; ret = 1;
        end
        "B": begin
          st = 5; sa = 2'b10; a = 1; pcs = 1; pcw = zz; ret = 1;
        end
        "J": begin
          st = 6; rfw = 1; ld = 2'b01; pcw = 1; pcs = 1; ret = 1;
        end
        default: begin
          st = 7; berr = 1;
        end
      endcase
    end
    return {3'b000, mreq, mwe, addr, irw, pcw, pcs, rfw, ld, sa, sb, im, a, comp, s, l, ex,
            ret, ill, berr, st};
  endfunction

  // One clock: drive inputs just after the edge, compare mid-cycle, step the model on the edge.
  task automatic run_cycle();
    byte  ph;
    logic rdy, zz;
    ph = plan[idx];
    rst = drv_rst;
    instr = (ph == "F" || ph == "H") ? $urandom : cur_instr;
    zz = 1'($urandom_range(1));
    z = zz;
    if (mem_hold > 0 && ph == "M") begin
      rdy = 1'b0;
      mem_hold--;
    end else begin
      rdy = ($urandom_range(99) < rdy_pct);
    end
    mem_ready = rdy;
    #4;
    check($sformatf("c%0d_%s_%c", cyc, e_name[cur], ph), act_vec, expect_vec(ph, rdy, zz, drv_rst));
    last_retire = retire;
    @(posedge clk);
    advance(rdy, drv_rst);
    cyc++;
    #1;
  endtask

  task automatic cpi_run(input string n, input int hold, input int exp_cpi);
    int cnt = 0;
    force_idx = find(n);
    mem_hold = hold;
    rdy_pct = 100;
    do begin
      run_cycle();
      cnt++;
    end while (!last_retire && cnt < 20);
    check({"cpi_", n}, 32'(cnt), 32'(exp_cpi));
  endtask

  task automatic run_to_mem(input string n);
    int guard = 0;
    drv_rst = 1'b1; run_cycle(); drv_rst = 1'b0;
    force_idx = find(n);
    rdy_pct = 100;
    while (plan[idx] != "M" && guard < 10) begin
      run_cycle();
      guard++;
    end
    check({"reach_mem_", n}, 32'(plan[idx] == "M"), 32'd1);
  endtask

  initial begin
    add_e("add",  "R", 7'b0110011, 3'b000, 0, 8'b0_0_00_00_00);
    add_e("sub",  "R", 7'b0110011, 3'b000, 1, 8'b1_0_00_00_00);
    add_e("sll",  "R", 7'b0110011, 3'b001, 0, 8'b0_0_00_00_11);
    add_e("slt",  "R", 7'b0110011, 3'b010, 0, 8'b1_1_00_00_01);
    add_e("sltu", "R", 7'b0110011, 3'b011, 0, 8'b1_0_00_00_01);
    add_e("xor",  "R", 7'b0110011, 3'b100, 0, 8'b0_0_00_00_10);
    add_e("srl",  "R", 7'b0110011, 3'b101, 0, 8'b0_0_10_00_11);
    add_e("sra",  "R", 7'b0110011, 3'b101, 1, 8'b0_0_11_00_11);
    add_e("or",   "R", 7'b0110011, 3'b110, 0, 8'b0_0_00_01_10);
    add_e("and",  "R", 7'b0110011, 3'b111, 0, 8'b0_0_00_10_10);
    add_e("addi", "I", 7'b0010011, 3'b000, 2, 8'b0_0_00_00_00);
    add_e("slti", "I", 7'b0010011, 3'b010, 2, 8'b1_1_00_00_01);
    add_e("sltiu","I", 7'b0010011, 3'b011, 2, 8'b1_0_00_00_01);
    add_e("xori", "I", 7'b0010011, 3'b100, 2, 8'b0_0_00_00_10);
    add_e("ori",  "I", 7'b0010011, 3'b110, 2, 8'b0_0_00_01_10);
    add_e("andi", "I", 7'b0010011, 3'b111, 2, 8'b0_0_00_10_10);
    add_e("slli", "I", 7'b0010011, 3'b001, 0, 8'b0_0_00_00_11);
    add_e("srli", "I", 7'b0010011, 3'b101, 0, 8'b0_0_10_00_11);
    add_e("srai", "I", 7'b0010011, 3'b101, 1, 8'b0_0_11_00_11);
    add_e("lw",   "L", 7'b0000011, 3'b010, 2, 8'h00);
    add_e("sw",   "S", 7'b0100011, 3'b010, 2, 8'h00);
    add_e("beq",  "B", 7'b1100011, 3'b000, 2, 8'h00);
    add_e("jal",  "J", 7'b1101111, 3'b000, 2, 8'h00);
    add_e("ill",  "X", 7'b1111111, 3'b000, 2, 8'h00);

    rst = 1'b1; instr = '0; z = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    drv_rst = 1'b1;
    repeat (3) run_cycle();
    drv_rst = 1'b0;

    cpi_run("add", 0, 4);
    cpi_run("sub", 0, 4);
    cpi_run("srai", 0, 4);
    cpi_run("lw", 3, 8);
    cpi_run("sw", 0, 4);
    cpi_run("beq", 0, 3);
    cpi_run("jal", 0, 3);
    cpi_run("lw", 0, 5);

    rdy_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      drv_rst = ($urandom_range(99) == 0);
      run_cycle();
    end
    drv_rst = 1'b0;

    // Fetch watchdog: sixteen unanswered cycles enter HALT, which ignores later readies.
    drv_rst = 1'b1; run_cycle(); drv_rst = 1'b0;
    rdy_pct = 0;
    repeat (16) run_cycle();
    check("halt_state", {29'b0, state}, 32'd7);
    check("halt_bus_err", {31'b0, bus_err}, 32'd1);
    rdy_pct = 100;
    repeat (3) run_cycle();

    // Ready on the would-be timeout cycle completes the fetch instead.
    drv_rst = 1'b1; run_cycle(); drv_rst = 1'b0;
    rdy_pct = 0;
    repeat (15) run_cycle();
    rdy_pct = 100;
    force_idx = find("add");
    run_cycle();
    check("late_ready_state", {29'b0, state}, 32'd1);
    repeat (4) run_cycle();

    run_to_mem("lw");
    rdy_pct = 0;
    repeat (16) run_cycle();
    check("mem_halt_state", {29'b0, state}, 32'd7);
    run_cycle();

    run_to_mem("sw");
    rdy_pct = 0;
    run_cycle();
    drv_rst = 1'b1;
    run_cycle();
    drv_rst = 1'b0;
    rdy_pct = 100;
    repeat (6) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM for the multi-cycle RV32I core.
- It sequences the shared datapath over several cycles, one instruction at a time:
  - a single ALU, used for PC+4, branch target and execute;
  - one unified instruction/data memory port with a req/ready handshake;
  - IR, oldPC, ALUOut and MDR registers.
- Supported instructions: R-type ALU, I-type ALU, LW, SW, BEQ, JAL.
- A memory-wait watchdog halts the core on a hung bus.

Parameters:
- TIMEOUT_CYCLES, 16: maximum consecutive wait cycles with mem_req=1 and mem_ready=0 before entering HALT. A value of 0 disables the watchdog.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- instr  in  32  IR contents. Valid from DECODE onward.
- z  in  1  ALU zero flag (combinational, current cycle).
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store (valid with mem_req).
- sel_addr  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_wen  out  1  IR and oldPC load.
- pc_wen  out  1  PC load.
- sel_pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
- RF_WEN  out  1  register-file write.
- sel_ld  out  2  RF write data: 00=ALUOut, 01=PC, 10=MDR.
- sel_srcA  out  2  ALU A: 00=PC, 01=oldPC, 10=rs1.
- sel_srcB  out  2  ALU B: 00=rs2, 01=imm, 10=constant 4.
- sel_imm  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- sel_a, sel_comp  out  1 each  add/sub select; unsigned/signed compare.
- sel_s, sel_l, sel_exec_out  out  2 each  shift, logic and exec-unit result selects.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse when an unsupported opcode is found in DECODE.
- bus_err  out  1  high while in HALT.
- state  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JAL=6, HALT=7.
- Default for every output not listed for a state is 0. Don't-care ALU selects are driven 0.
- ALU default is add: sel_a=0, sel_exec_out=00.
- Reset:
  - rst=1 at a clock edge sets state to FETCH and clears the wait counter.
  - While rst=1, every output is 0, including mem_req. An in-flight transaction is abandoned without a store.
- FETCH:
  - Drives mem_req=1, sel_addr=0, sel_srcA=00, sel_srcB=10.
  - On the handshake cycle (mem_req & mem_ready): ir_wen=1, pc_wen=1, sel_pc_src=0, next state DECODE.
  - Otherwise stays in FETCH.
- DECODE:
  - Drives sel_srcA=01, sel_srcB=01, sel_imm=10 for opcode 1100011 and 11 otherwise; ALUOut captures the target.
  - Next state by opcode: 0110011, 0010011, 0000011, 0100011 go to EXEC; 1100011 goes to BRANCH; 1101111 goes to JAL.
  - Any other opcode pulses illegal and returns to FETCH with no retire.
- EXEC:
  - Drives sel_srcA=10.
  - R-type: sel_srcB=00. I-ALU and LW: sel_srcB=01, sel_imm=00. SW: sel_srcB=01, sel_imm=01.
  - ALU selects for R/I: decode {func3, instr[30]}:
    - add/addi: sub only when R-type with instr[30]=1 (sel_a=1).
    - slt: sel_a=1, sel_comp=1, exec=01. sltu: sel_a=1, sel_comp=0, exec=01.
    - sll: s=00, exec=11. srl: s=10, exec=11. sra: s=11, exec=11.
    - xor: l=00, exec=10. or: l=01, exec=10. and: l=10, exec=10.
  - LW/SW use add.
  - Next state: LW/SW go to MEM; R/I go to WB.
- MEM:
  - Drives mem_req=1, sel_addr=1, mem_we=1 only for SW.
  - On handshake: LW goes to WB (MDR captures); SW pulses retire and goes to FETCH.
- WB:
  - Drives RF_WEN=1, sel_ld=10 for LW and 00 otherwise.
  - Pulses retire; next state FETCH.
- BRANCH:
  - Drives sel_srcA=10, sel_srcB=00, sel_a=1, sel_pc_src=1, pc_wen=z.
  - Pulses retire; next state FETCH.
- JAL:
  - Drives RF_WEN=1, sel_ld=01 (PC already holds PC+4), pc_wen=1, sel_pc_src=1.
  - Pulses retire; next state FETCH.
- Watchdog:
  - The wait counter clears on every state change and on handshake.
  - It increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT_CYCLES (if nonzero), next state is HALT.
  - mem_ready arriving in that same cycle wins: the handshake completes and HALT is not entered.
- HALT: bus_err=1, all other outputs 0; stays until rst.
- CPI: ALU instructions 4, LW 5, SW 4, BEQ 3, JAL 3, each plus memory wait cycles.

Test Plan:
- Reset, then mem_ready=1 continuously, `add x3,x1,x2` (0x002081B3):
  - states 0,1,2,4,0;
  - EXEC shows sel_srcA=10, sel_srcB=00, sel_a=0;
  - WB shows RF_WEN=1, sel_ld=00, retire=1;
  - CPI 4.
- `sub` (0x402081B3) gives sel_a=1 in EXEC. `srai` (0x4020D193) gives sel_srcB=01, sel_s=11, sel_exec_out=11.
- `lw` with mem_ready low for 3 cycles in MEM:
  - mem_req=1, sel_addr=1 held for 4 cycles;
  - WB shows sel_ld=10;
  - total 8 cycles.
- `sw`: MEM shows mem_we=1, retire pulses on the handshake, RF_WEN is never 1. `beq` with z=1 gives pc_wen=1, sel_pc_src=1; with z=0 gives pc_wen=0. Both take 3 cycles.
- `jal` gives RF_WEN=1, sel_ld=01, pc_wen=1 in state 6. Opcode 0x7F pulses illegal in DECODE, then FETCH with no retire.
- TIMEOUT_CYCLES=16 with mem_ready held 0: HALT is entered after 16 wait cycles and bus_err=1. Asserting rst mid-MEM of a `sw` drops mem_req the same cycle, state=FETCH, no mem_we.
